// File: rtl/stack_controller.sv
// -----------------------------------------------------------------------------
// stack_controller
//
// Sequences push/pop/peek on a downward-growing hardware stack. It shares the
// single-port 256x16 data memory between stack traffic and ordinary
// loads/stores, and stalls the upstream stage when both need the port in the
// same cycle.
//
// Parameters:
//   STACK_BASE   bottom (first) stack slot; an empty stack has SP == STACK_BASE
//   STACK_LIMIT  lowest usable slot (must be >= 1); full when SP == STACK_LIMIT-1
//
// Ports:
//   CLK, RST                clock, synchronous active-high reset
//   stack_command/stack_ctl stack request; 00 none, 01 push, 10 pop, 11 peek
//   push_data               value to push
//   data_read/data_write    ordinary access requests (write wins if both)
//   data_addr/data_wdata    ordinary access address / write data
//   mem_rdata               memory read data, valid one cycle after mem_re
//   mem_addr/mem_wdata/mem_we/mem_re  memory port (combinational)
//   stall                   upstream stage holds this cycle (combinational)
//   pop_data/pop_valid      popped or peeked value; pop_data is 0 when not valid
//   stack_pointer           next free slot (registered)
//   overflow/underflow      sticky error flags (registered)
//
// Build option:
//   STACK_GUARD_EN  defined: full/empty checks and sticky overflow/underflow.
//                   undefined: push/pop always execute, SP wraps modulo 256,
//                   and both flags stay 0.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | accept stack op or pass ordinary access straight through
// ST_POP_WAIT  | stack read data returning; present pop_data, serve data access
// ST_DATA_PEND | push took the port last cycle; serve the held data access
// -----------------------------------------------------------------------------
module stack_controller #(
  parameter logic [7:0] STACK_BASE  = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stack_command,
  input  logic [1:0]  stack_ctl,
  input  logic [15:0] push_data,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [7:0]  data_addr,
  input  logic [15:0] data_wdata,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        stall,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic [7:0]  stack_pointer,
  output logic        overflow,
  output logic        underflow
);

`ifdef STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_POP_WAIT  = 2'd1,
    ST_DATA_PEND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sp_q, sp_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic op_push, op_read, op_pop, full, empty;

  assign op_push = stack_command && (stack_ctl == 2'b01);
  assign op_read = stack_command && stack_ctl[1];
  assign op_pop  = stack_command && (stack_ctl == 2'b10);

  // With the guard disabled these are constant 0, so every op executes and
  // the flags can never set.
  assign full  = GUARD_EN && (sp_q == (STACK_LIMIT - 8'd1));
  assign empty = GUARD_EN && (sp_q == STACK_BASE);

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    // Default port behaviour is ordinary-access pass-through.
    mem_addr  = data_addr;
    mem_wdata = data_wdata;
    mem_we    = data_write;
    mem_re    = data_read & ~data_write;
    stall     = 1'b0;
    pop_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_push) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_re    = 1'b0;
            mem_addr  = sp_q;
            mem_wdata = push_data;
            sp_d      = sp_q - 8'd1;
            if (data_read || data_write) begin
              stall   = 1'b1;
              state_d = ST_DATA_PEND;
            end
          end
        end else if (op_read) begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            mem_we   = 1'b0;
            mem_re   = 1'b1;
            mem_addr = sp_q + 8'd1;
            if (op_pop) sp_d = sp_q + 8'd1;
            stall    = 1'b1;
            state_d  = ST_POP_WAIT;
          end
        end
      end
      ST_POP_WAIT: begin
        // The held stack command belongs to the same instruction; ignore it.
        pop_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_DATA_PEND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset aborts whatever is in flight; nothing reaches the port.
    if (RST) begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      stall     = 1'b0;
      pop_valid = 1'b0;
    end
  end

  assign pop_data = pop_valid ? mem_rdata : 16'h0000;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sp_q    <= STACK_BASE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign stack_pointer = sp_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_stack_controller.sv
// -----------------------------------------------------------------------------
// tb_stack_controller
//
// Self-checking bench for stack_controller. A behavioural 256x16 memory with
// one-cycle read latency sits on the port. Expected memory writes and expected
// popped values are queued when stimulus is driven and compared when the DUT
// produces them. Guard-specific checks follow STACK_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_stack_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stack_command;
  logic [1:0]  stack_ctl;
  logic [15:0] push_data;
  logic        data_read;
  logic        data_write;
  logic [7:0]  data_addr;
  logic [15:0] data_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        stall;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [7:0]  stack_pointer;
  logic        overflow;
  logic        underflow;

  stack_controller dut (
    .CLK           (CLK),
    .RST           (RST),
    .stack_command (stack_command),
    .stack_ctl     (stack_ctl),
    .push_data     (push_data),
    .data_read     (data_read),
    .data_write    (data_write),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .mem_rdata     (mem_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .stall         (stall),
    .pop_data      (pop_data),
    .pop_valid     (pop_valid),
    .stack_pointer (stack_pointer),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 CLK = ~CLK;

  // Memory model: synchronous write, registered read.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
  end
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_pop_q[$];
  logic [15:0] mstk[$];
  logic [7:0]  sp_m;

  wr_t         mon_wr;
  logic [15:0] mon_pop;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          check_val("unexpected_we", mem_we, 0);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check_val("wr_addr", mem_addr, mon_wr.addr);
          check_val("wr_data", mem_wdata, mon_wr.data);
        end
      end
      if (pop_valid) begin
        if (exp_pop_q.size() == 0) begin
          check_val("unexpected_pop_valid", pop_valid, 0);
        end else begin
          mon_pop = exp_pop_q.pop_front();
          check_val("pop_data", pop_data, mon_pop);
        end
      end else begin
        check_val("pop_data_idle_zero", pop_data, 0);
      end
    end
  end

  task automatic set_in(input logic cmd, input logic [1:0] ctl, input logic [15:0] pd,
                        input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] wd);
    stack_command = cmd;
    stack_ctl     = ctl;
    push_data     = pd;
    data_read     = rd;
    data_write    = wr;
    data_addr     = a;
    data_wdata    = wd;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    mstk.delete();
    exp_wr_q.delete();
    exp_pop_q.delete();
    sp_m = 8'hFF;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_in(0, 2'b00, 16'h0, 0, 0, 8'h0, 16'h0);
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check_val("rst_stall", stall, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_pop_valid", pop_valid, 0);
    check_val("rst_pop_data", pop_data, 0);
    next_cycle();
    RST = 1'b0;
    model_reset();
    check_val("rst_sp", stack_pointer, 8'hFF);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_underflow", underflow, 0);
  endtask

  task automatic do_push(input logic [15:0] pd, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [15:0] wd);
    wr_t e;
    e.addr = sp_m;
    e.data = pd;
    exp_wr_q.push_back(e);
    if (wr) begin
      e.addr = a;
      e.data = wd;
      exp_wr_q.push_back(e);
    end
    mstk.push_back(pd);
    sp_m = sp_m - 8'd1;
    set_in(1, 2'b01, pd, rd, wr, a, wd);
    @(negedge CLK);
    check_val("push_stall", stall, rd | wr);
    if (rd | wr) begin
      next_cycle();
      @(negedge CLK);
      check_val("pend_stall", stall, 0);
      if (rd && !wr) begin
        check_val("pend_mem_re", mem_re, 1);
        check_val("pend_mem_addr", mem_addr, a);
      end
    end
    next_cycle();
    check_val("push_sp", stack_pointer, sp_m);
  endtask

  // An empty model stack only happens in the wrap test, where the slot read
  // back has never been written and so holds 0.
  task automatic do_pop(input logic peek, input logic rd, input logic [7:0] a);
    logic [15:0] e;
    logic [7:0]  ra;
    e  = (mstk.size() > 0) ? mstk[$] : 16'h0000;
    ra = sp_m + 8'd1;
    exp_pop_q.push_back(e);
    if (!peek) begin
      if (mstk.size() > 0) void'(mstk.pop_back());
      sp_m = sp_m + 8'd1;
    end
    set_in(1, peek ? 2'b11 : 2'b10, 16'h0, rd, 0, a, 16'h0);
    @(negedge CLK);
    check_val("pop_n_stall", stall, 1);
    check_val("pop_n_mem_re", mem_re, 1);
    check_val("pop_n_mem_addr", mem_addr, ra);
    check_val("pop_n_valid", pop_valid, 0);
    next_cycle();
    @(negedge CLK);
    check_val("pop_n1_stall", stall, 0);
    check_val("pop_n1_valid", pop_valid, 1);
    if (rd) begin
      check_val("pop_n1_mem_re", mem_re, 1);
      check_val("pop_n1_mem_addr", mem_addr, a);
    end
    next_cycle();
    check_val("pop_sp", stack_pointer, sp_m);
  endtask

  initial begin
    RST = 1'b1;
    set_in(0, 2'b00, 16'h0, 0, 0, 8'h0, 16'h0);
    model_reset();
    do_reset();

    // Basic LIFO ordering.
    do_push(16'hA5A5, 0, 0, 8'h0, 16'h0);
    do_push(16'h1234, 0, 0, 8'h0, 16'h0);
    do_pop(0, 0, 8'h0);
    do_pop(0, 0, 8'h0);
    check_val("lifo_sp_back", stack_pointer, 8'hFF);

    // Peek leaves SP alone.
    do_push(16'hBEEF, 0, 0, 8'h0, 16'h0);
    do_pop(1, 0, 8'h0);
    check_val("peek_sp", stack_pointer, 8'hFE);
    do_pop(0, 0, 8'h0);

    // Port conflicts.
    do_push(16'h0001, 0, 1, 8'h10, 16'h5555);
    do_pop(0, 1, 8'h20);
    do_push(16'h0002, 1, 0, 8'h21, 16'h0);
    do_pop(0, 0, 8'h0);

    // Pass-through from IDLE.
    set_in(0, 2'b00, 16'h0, 1, 0, 8'h33, 16'h0);
    @(negedge CLK);
    check_val("pt_rd_re", mem_re, 1);
    check_val("pt_rd_addr", mem_addr, 8'h33);
    check_val("pt_rd_stall", stall, 0);
    next_cycle();
    begin
      wr_t e;
      e.addr = 8'h34; e.data = 16'hCAFE;
      exp_wr_q.push_back(e);
      set_in(0, 2'b00, 16'h0, 1, 1, 8'h34, 16'hCAFE);
      @(negedge CLK);
      check_val("pt_both_re", mem_re, 0);
      check_val("pt_both_stall", stall, 0);
      next_cycle();
      e.addr = 8'h35; e.data = 16'hD00D;
      exp_wr_q.push_back(e);
      set_in(1, 2'b00, 16'h7777, 0, 1, 8'h35, 16'hD00D);
      @(negedge CLK);
      check_val("pt_ctl00_stall", stall, 0);
      next_cycle();
      check_val("pt_ctl00_sp", stack_pointer, sp_m);
    end

    // Reset during DATA_PEND: the held data write must not happen.
    begin
      wr_t e;
      e.addr = sp_m; e.data = 16'h7777;
      exp_wr_q.push_back(e);
      set_in(1, 2'b01, 16'h7777, 0, 1, 8'h44, 16'h9999);
      @(negedge CLK);
      check_val("abort_push_stall", stall, 1);
      next_cycle();
      RST = 1'b1;
      @(negedge CLK);
      check_val("abort_pend_we", mem_we, 0);
      check_val("abort_pend_stall", stall, 0);
      next_cycle();
      RST = 1'b0;
      set_in(0, 2'b00, 16'h0, 0, 0, 8'h0, 16'h0);
      model_reset();
      check_val("abort_pend_sp", stack_pointer, 8'hFF);
    end

    // Reset during POP_WAIT: no pop result is presented.
    do_push(16'h1111, 0, 0, 8'h0, 16'h0);
    set_in(1, 2'b10, 16'h0, 0, 0, 8'h0, 16'h0);
    @(negedge CLK);
    check_val("abort_pop_stall", stall, 1);
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    check_val("abort_pop_valid", pop_valid, 0);
    check_val("abort_pop_data", pop_data, 0);
    next_cycle();
    RST = 1'b0;
    set_in(0, 2'b00, 16'h0, 0, 0, 8'h0, 16'h0);
    model_reset();
    next_cycle();
    check_val("abort_pop_sp", stack_pointer, 8'hFF);
    check_val("abort_pop_stall_after", stall, 0);

`ifdef STACK_GUARD_EN
    do_reset();
    for (int i = 0; i < 64; i++) do_push(16'h4000 + 16'(i), 0, 0, 8'h0, 16'h0);
    check_val("full_sp", stack_pointer, 8'hBF);
    set_in(1, 2'b01, 16'hDEAD, 0, 0, 8'h0, 16'h0);
    @(negedge CLK);
    check_val("ovf_no_we", mem_we, 0);
    check_val("ovf_no_stall", stall, 0);
    next_cycle();
    check_val("ovf_sp", stack_pointer, 8'hBF);
    check_val("ovf_flag", overflow, 1);
    do_reset();
    set_in(1, 2'b10, 16'h0, 0, 0, 8'h0, 16'h0);
    @(negedge CLK);
    check_val("unf_no_re", mem_re, 0);
    check_val("unf_no_stall", stall, 0);
    next_cycle();
    set_in(0, 2'b00, 16'h0, 0, 0, 8'h0, 16'h0);
    @(negedge CLK);
    check_val("unf_no_valid", pop_valid, 0);
    check_val("unf_flag", underflow, 1);
    check_val("unf_sp", stack_pointer, 8'hFF);
`else
    // No guard: pop on empty reads slot 00 and SP wraps, push at 00 wraps back.
    do_reset();
    do_pop(0, 0, 8'h0);
    check_val("wrap_pop_sp", stack_pointer, 8'h00);
    do_push(16'h4242, 0, 0, 8'h0, 16'h0);
    check_val("wrap_push_sp", stack_pointer, 8'hFF);
    check_val("noguard_ovf", overflow, 0);
    check_val("noguard_unf", underflow, 0);
`endif

    set_in(0, 2'b00, 16'h0, 0, 0, 8'h0, 16'h0);
    next_cycle();
    next_cycle();
    check_val("wr_q_drained", exp_wr_q.size(), 0);
    check_val("pop_q_drained", exp_pop_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequences push/pop/peek operations on the hardware stack and shares the single-port 256×16 data memory between stack traffic and ordinary loads and stores. It sits after the execution pipeline register. It consumes that stage's `stack_command`, `stack_ctl`, `result`, `data_read`, `data_write` and `addr` fields. It drives the data-memory port, owns the stack pointer, and stalls the pipeline whenever a stack access and a data access cannot share the port in one cycle.

## Interface
- `STACK_BASE`, 8'hFF: address of the first (bottom) stack slot; the stack grows downward.
- `STACK_LIMIT`, 8'hC0: lowest usable stack slot; depth = `STACK_BASE - STACK_LIMIT + 1` (64 by default). Requires `STACK_LIMIT >= 1`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `stack_command` in 1: a stack operation is requested.
- `stack_ctl` in 2: operation code; 00 = none, 01 = push, 10 = pop, 11 = peek.
- `push_data` in 16: value to push.
- `data_read`, `data_write` in 1 each: ordinary memory access requests.
- `data_addr` in 8: address for the ordinary access.
- `data_wdata` in 16: write data for the ordinary access.
- `mem_rdata` in 16: memory read data, valid one cycle after `mem_re`.
- `mem_addr` out 8, `mem_wdata` out 16, `mem_we` out 1, `mem_re` out 1: memory port.
- `stall` out 1: upstream stage must hold its contents this cycle.
- `pop_data` out 16: popped or peeked value.
- `pop_valid` out 1: `pop_data` is valid this cycle.
- `stack_pointer` out 8: next free slot.
- `overflow`, `underflow` out 1 each: sticky error flags.

## Operation
- SP points to the next free slot.
  - Empty: SP == `STACK_BASE`.
  - Full: SP == `STACK_LIMIT - 1`.
  - All SP arithmetic is 8-bit.
- States: IDLE, POP_WAIT, DATA_PEND. A stack op is active when `stack_command` = 1 and `stack_ctl` != 00.
- IDLE, no active stack op: the ordinary access passes through combinationally.
  - `mem_addr=data_addr`, `mem_wdata=data_wdata`, `mem_we=data_write`, `mem_re=data_read & ~data_write`. If both requests are set, the write wins.
  - `stall=0`.
- IDLE, push, not full:
  - `mem_we=1`, `mem_addr=SP`, `mem_wdata=push_data`; SP <= SP−1.
  - If `data_read|data_write` is also set: `stall=1` and go to DATA_PEND. Otherwise stay in IDLE with `stall=0`.
- IDLE, pop or peek, not empty:
  - `mem_re=1`, `mem_addr=SP+1`; a pop also does SP <= SP+1.
  - `stall=1`; go to POP_WAIT.
- POP_WAIT:
  - `pop_valid=1`, `pop_data=mem_rdata`; `stall=0`; the stack command (same instruction, still held) is ignored.
  - Any pending ordinary access is served on the port exactly as in IDLE pass-through.
  - Go to IDLE.
- DATA_PEND:
  - Stack command ignored; ordinary access served as in pass-through; `stall=0`; go to IDLE.
- Push when full: no write, SP unchanged, `overflow` <= 1, no stall; any ordinary access passes through.
- Pop or peek when empty: no read, SP unchanged, `underflow` <= 1, `pop_valid` stays 0, no stall; any ordinary access passes through.
- `pop_data` = 0 whenever `pop_valid` = 0.
- Reset values: state IDLE; SP = `STACK_BASE`; `overflow` = `underflow` = 0; `stall`, `mem_we`, `mem_re` and `pop_valid` = 0; `pop_data` = 0.
- Reset asserted in any state, including POP_WAIT or DATA_PEND: the operation is aborted, `mem_we` = 0 that cycle, and no pending access is replayed.

## Timing
- Push without a conflicting access: 1 cycle, no stall; SP updates at the same edge as the write.
- Pop/peek: read issued in cycle N with `stall=1`; `pop_valid` in cycle N+1 with data from `mem_rdata`; the instruction advances at the end of N+1.
- Push with a conflicting access: push in cycle N (stalled); ordinary access in cycle N+1; the instruction advances at the end of N+1.
- `stall` is combinational from state and inputs. Port outputs are combinational.
- `stack_pointer`, `overflow`, `underflow` and the state are registered.

## Configuration
- `STACK_GUARD_EN` defined: full/empty checks, `overflow` and `underflow` behave as above.
- `STACK_GUARD_EN` undefined:
  - No full/empty checks; push and pop always execute.
  - SP wraps modulo 256 (push at 8'h00 writes 8'h00 and SP becomes 8'hFF).
  - `overflow` and `underflow` are tied to 0.

## Test plan
- Reset: assert `RST` for 2 cycles → SP = 8'hFF, `stall`=0, `mem_we`=0, `pop_valid`=0, both flags 0.
- Push 16'hA5A5 then 16'h1234, then pop twice:
  - Writes land at FF then FE.
  - Pops return 16'h1234 then 16'hA5A5, each with a 1-cycle `stall` and `pop_valid` in the following cycle.
  - SP returns to 8'hFF.
- Peek after pushing 16'hBEEF → `pop_data`=16'hBEEF, SP stays 8'hFE.
- Push 16'h0001 together with `data_write` (addr 8'h10, data 16'h5555):
  - Cycle N: `stall`=1, write to FF.
  - Cycle N+1: write of 16'h5555 to 8'h10, `stall`=0.
- Pop together with `data_read` at 8'h20:
  - Cycle N: stack read at SP+1 with `stall`=1.
  - Cycle N+1: `pop_valid`=1 and `mem_re` at 8'h20.
- 64 pushes, then a 65th (guard enabled) → SP = 8'hBF, no write, `overflow`=1. After reset, pop on empty → `underflow`=1, `pop_valid`=0.
